// File: rtl/load_store_unit_if.sv
// Core/memory-side signal bundle for the load/store unit.
// The master modport is the requester plus memory model; the slave modport is the LSU.
interface load_store_unit_if;
   logic        i_start;
   logic [5:0]  i_opcode;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_rdata;
   logic        o_addr_err;
   logic        o_bus_err;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   modport master (
      output i_start, i_opcode, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
      input  o_busy, o_done, o_rdata, o_addr_err, o_bus_err,
             o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
   );

   modport slave (
      input  i_start, i_opcode, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
      output o_busy, o_done, o_rdata, o_addr_err, o_bus_err,
             o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// MIPS byte/half/word load-store unit: one outstanding access, lane steering,
// load extension, alignment checking and an ack timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic               i_clk,
   input logic               i_rst_n,
   load_store_unit_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nx;
   logic [7:0]  cnt;
   logic [5:0]  op_q;
   logic [1:0]  lane_q;
   logic [31:0] rdata_q;
   logic        addr_err_q, bus_err_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [3:0]  mem_be_q;

   logic        legal, aligned;
   logic        start_ok, start_bad, ack_ok, tmo;

   // Encoding: op[3] = store, op[1:0] = size (00 byte, 01 half, 11 word), op[2] = unsigned load.
   always_comb begin
      legal = 1'b0;
      case (bus.i_opcode)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      case (bus.i_opcode[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~bus.i_addr[0];
         default: aligned = (bus.i_addr[1:0] == 2'b00);
      endcase
   end

   function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b00:   return 4'b0001 << lane;
         2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] lane,
                                           input logic [31:0] d);
      logic [31:0] s;
      logic [15:0] h;
      s = d >> {lane, 3'b000};
      h = lane[1] ? d[31:16] : d[15:0];
      case (op)
         OP_LB:   return {{24{s[7]}}, s[7:0]};
         OP_LBU:  return {24'd0, s[7:0]};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'd0, h};
         default: return d;
      endcase
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      start_ok  = 1'b0;
      start_bad = 1'b0;
      ack_ok    = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_start) begin
               if (legal && aligned) begin
                  start_ok = 1'b1;
                  state_nx = ACCESS;
               end else begin
                  start_bad = 1'b1;
                  state_nx  = RESP;
               end
            end
         end
         ACCESS: begin
            if (bus.i_mem_ack) begin
               ack_ok   = 1'b1;
               state_nx = RESP;
            end else if (cnt == TMO_LAST) begin
               tmo      = 1'b1;
               state_nx = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Bus fields are frozen at start so they stay constant for the whole access.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt         <= '0;
         op_q        <= '0;
         lane_q      <= '0;
         rdata_q     <= '0;
         addr_err_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
      end else begin
         addr_err_q <= start_bad;
         bus_err_q  <= tmo;
         if (start_ok) begin
            cnt         <= '0;
            op_q        <= bus.i_opcode;
            lane_q      <= bus.i_addr[1:0];
            mem_we_q    <= bus.i_opcode[3];
            mem_addr_q  <= {bus.i_addr[31:2], 2'b00};
            mem_be_q    <= calc_be(bus.i_opcode[1:0], bus.i_addr[1:0]);
            mem_wdata_q <= calc_wdata(bus.i_opcode[1:0], bus.i_wdata);
         end else if (state == ACCESS) begin
            cnt <= cnt + 8'd1;
         end
         if (ack_ok && !op_q[3])
            rdata_q <= extract(op_q, lane_q, bus.i_mem_rdata);
      end
   end

   assign bus.o_busy      = (state != IDLE);
   assign bus.o_done      = (state == RESP);
   assign bus.o_mem_req   = (state == ACCESS);
   assign bus.o_rdata     = rdata_q;
   assign bus.o_addr_err  = addr_err_q;
   assign bus.o_bus_err   = bus_err_q;
   assign bus.o_mem_we    = mem_we_q;
   assign bus.o_mem_addr  = mem_addr_q;
   assign bus.o_mem_be    = mem_be_q;
   assign bus.o_mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed lane, extension, latency,
// error and reset expectations.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   load_store_unit_if bus();

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int          lat, busy_pre, req_cyc, err_outside;
   logic        seen_done, cap_we, d_aerr, d_berr;
   logic [3:0]  cap_be;
   logic [31:0] cap_addr, cap_wdata, d_rdata;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and play memory: ack on the (waits+1)-th request cycle if ack_en.
   task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic ack_en);
      bus.i_start  = 1'b1;
      bus.i_opcode = op;
      bus.i_addr   = addr;
      bus.i_wdata  = wd;
      step();
      bus.i_start = 1'b0;
      lat = 0; busy_pre = 0; req_cyc = 0; err_outside = 0; seen_done = 1'b0;
      cap_we = 1'b0; cap_be = '0; cap_addr = '0; cap_wdata = '0;
      for (int c = 1; c <= 40 && !seen_done; c++) begin
         if (bus.o_done) begin
            lat = c; seen_done = 1'b1;
            d_rdata = bus.o_rdata; d_aerr = bus.o_addr_err; d_berr = bus.o_bus_err;
         end else begin
            if (bus.o_busy) busy_pre++;
            if (bus.o_addr_err || bus.o_bus_err) err_outside++;
         end
         if (bus.o_mem_req) begin
            req_cyc++;
            cap_we = bus.o_mem_we; cap_be = bus.o_mem_be;
            cap_addr = bus.o_mem_addr; cap_wdata = bus.o_mem_wdata;
            bus.i_mem_ack   = ack_en && (req_cyc == waits + 1);
            bus.i_mem_rdata = rd;
         end else begin
            bus.i_mem_ack = 1'b0;
         end
         if (!seen_done) step();
      end
      bus.i_mem_ack = 1'b0;
      chk("done_seen", 32'(seen_done), 32'd1);
      step();
      chk("done_one_cycle", 32'(bus.o_done), 32'd0);
      chk("err_only_in_done", 32'(err_outside), 32'd0);
   endtask

   initial begin
      int ndone;
      bus.i_start = 1'b0; bus.i_opcode = '0; bus.i_addr = '0; bus.i_wdata = '0;
      bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
      #1;
      chk("rst_busy",  32'(bus.o_busy), 32'd0);
      chk("rst_done",  32'(bus.o_done), 32'd0);
      chk("rst_rdata", bus.o_rdata, 32'd0);
      chk("rst_req",   32'(bus.o_mem_req), 32'd0);
      chk("rst_we",    32'(bus.o_mem_we), 32'd0);
      chk("rst_maddr", bus.o_mem_addr, 32'd0);
      chk("rst_be",    32'(bus.o_mem_be), 32'd0);
      chk("rst_wdata", bus.o_mem_wdata, 32'd0);
      chk("rst_errs",  32'({bus.o_addr_err, bus.o_bus_err}), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();

      // LB, lane 3, zero waits
      do_op(6'b100000, 32'h1003, 32'h0, 0, 32'h80AABBCC, 1'b1);
      chk("lb_be", 32'(cap_be), 32'h8);
      chk("lb_we", 32'(cap_we), 32'd0);
      chk("lb_maddr", cap_addr, 32'h1000);
      chk("lb_lat", 32'(lat), 32'd2);
      chk("lb_rdata", d_rdata, 32'hFFFFFF80);
      chk("lb_errs", 32'({d_aerr, d_berr}), 32'd0);

      // LHU, upper half, three waits
      do_op(6'b100101, 32'h2002, 32'h0, 3, 32'h80011234, 1'b1);
      chk("lhu_be", 32'(cap_be), 32'hC);
      chk("lhu_lat", 32'(lat), 32'd5);
      chk("lhu_busy_before_done", 32'(busy_pre), 32'd4);
      chk("lhu_req_cycles", 32'(req_cyc), 32'd4);
      chk("lhu_rdata", d_rdata, 32'h00008001);

      // SH, lower half
      do_op(6'b101001, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b1);
      chk("sh_we", 32'(cap_we), 32'd1);
      chk("sh_be", 32'(cap_be), 32'h3);
      chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);
      chk("sh_maddr", cap_addr, 32'h10);
      chk("sh_rdata_held", d_rdata, 32'h00008001);

      // Misaligned LW and illegal opcode
      do_op(6'b100011, 32'h6, 32'h0, 0, 32'h0, 1'b1);
      chk("lw_mis_req", 32'(req_cyc), 32'd0);
      chk("lw_mis_aerr", 32'(d_aerr), 32'd1);
      chk("lw_mis_lat", 32'(lat), 32'd1);
      chk("lw_mis_rdata", d_rdata, 32'h00008001);
      do_op(6'b000000, 32'h0, 32'h0, 0, 32'h0, 1'b1);
      chk("illop_req", 32'(req_cyc), 32'd0);
      chk("illop_aerr", 32'(d_aerr), 32'd1);
      chk("illop_lat", 32'(lat), 32'd1);
      do_op(6'b100001, 32'h101, 32'h0, 0, 32'h0, 1'b1);
      chk("lh_mis_aerr", 32'(d_aerr), 32'd1);

      // SW timeout
      do_op(6'b101011, 32'h20, 32'h11223344, 0, 32'h0, 1'b0);
      chk("sw_tmo_req", 32'(req_cyc), 32'd16);
      chk("sw_tmo_berr", 32'(d_berr), 32'd1);
      chk("sw_tmo_aerr", 32'(d_aerr), 32'd0);
      chk("sw_tmo_lat", 32'(lat), 32'd17);
      chk("sw_tmo_rdata", d_rdata, 32'h00008001);

      // Extra lanes and extensions
      do_op(6'b100100, 32'h101, 32'h0, 0, 32'h0000F100, 1'b1);
      chk("lbu_be", 32'(cap_be), 32'h2);
      chk("lbu_rdata", d_rdata, 32'h000000F1);
      do_op(6'b100001, 32'h102, 32'h0, 0, 32'hFFFE0000, 1'b1);
      chk("lh_rdata", d_rdata, 32'hFFFFFFFE);
      do_op(6'b100011, 32'h40, 32'h0, 1, 32'h12345678, 1'b1);
      chk("lw_be", 32'(cap_be), 32'hF);
      chk("lw_lat", 32'(lat), 32'd3);
      chk("lw_rdata", d_rdata, 32'h12345678);
      do_op(6'b101000, 32'h3, 32'h000000A5, 0, 32'h0, 1'b1);
      chk("sb_be", 32'(cap_be), 32'h8);
      chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
      chk("sb_rdata_held", d_rdata, 32'h12345678);

      // Starts while busy are dropped: LW with two waits, start pulsed in cycles 2 and 4
      bus.i_start = 1'b1; bus.i_opcode = 6'b100011; bus.i_addr = 32'h60;
      step();
      bus.i_start = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 12; c++) begin
         if (bus.o_done) ndone++;
         bus.i_start     = (c == 2 || c == 4);
         bus.i_mem_ack   = (c == 3);
         bus.i_mem_rdata = 32'hCAFEF00D;
         step();
      end
      bus.i_start = 1'b0; bus.i_mem_ack = 1'b0;
      chk("busy_start_dones", 32'(ndone), 32'd1);
      chk("busy_start_rdata", bus.o_rdata, 32'hCAFEF00D);

      // Ack in IDLE is ignored
      bus.i_mem_ack = 1'b1;
      step();
      chk("idle_ack_busy", 32'(bus.o_busy), 32'd0);
      bus.i_mem_ack = 1'b0;

      // Reset during an ACCESS wait
      bus.i_start = 1'b1; bus.i_opcode = 6'b101011; bus.i_addr = 32'h50;
      step();
      bus.i_start = 1'b0;
      step(); step();
      chk("mid_req_before", 32'(bus.o_mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_req_async", 32'(bus.o_mem_req), 32'd0);
      chk("mid_busy_async", 32'(bus.o_busy), 32'd0);
      chk("mid_rdata_async", bus.o_rdata, 32'd0);
      chk("mid_be_async", 32'(bus.o_mem_be), 32'd0);
      step();
      rst_n = 1'b1;
      ndone = 0;
      bus.i_mem_ack = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (bus.o_done || bus.o_busy) ndone++;
         step();
      end
      bus.i_mem_ack = 1'b0;
      chk("post_rst_ack_ignored", 32'(ndone), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
